// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
//
// Weighted round-robin arbiter. Each requester may keep the grant for up to
// its weight in consecutive cycles (a weight of 0 behaves as 1). When the
// burst ends, or the grantee drops its request, the next requester is chosen
// round-robin, starting one past the previous winner. Grant outputs are
// registered and appear one edge after the request is sampled.
//
// Optional feature (macro WRR_ARB_LOCK_EN):
//   Adds lock_in. While lock_in is high and the grantee keeps requesting,
//   the grant is held regardless of credit; credit saturates at 1.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   req_in           request vector, bit i = requester i
//   weight_in        per-requester weights, field i = [i*WEIGHT_W +: WEIGHT_W]
//   lock_in          (WRR_ARB_LOCK_EN only) hold the current grant
//   grant_out        registered one-hot grant, zero when idle
//   grant_valid_out  registered, high iff grant_out is non-zero
//   grant_id_out     registered index of the grantee, zero when idle
// ---------------------------------------------------------------------------
module wrr_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_in,
`ifdef WRR_ARB_LOCK_EN
  input  logic                        lock_in,
`endif
  output logic [NUM_REQ-1:0]          grant_out,
  output logic                        grant_valid_out,
  output logic [ID_W-1:0]             grant_id_out
);

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     cur_q, cur_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                active_q, active_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic                curReq;
  logic                foundHi, foundLo, found;
  logic [ID_W-1:0]     winHi, winLo, winner;
  logic [WEIGHT_W-1:0] winField, winWeight;
  logic                hold, lockHold;

  // Is the current grantee still requesting? Looping over constant indices
  // keeps the select free of width mismatches for any NUM_REQ.
  always_comb begin
    curReq = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_q == ID_W'(i)) begin
        curReq = req_in[i];
      end
    end
  end

  // Round-robin search split into two passes: the lowest requester at or
  // above ptr wins; failing that, the lowest requester below ptr (the wrap).
  always_comb begin
    foundHi = 1'b0;
    foundLo = 1'b0;
    winHi   = '0;
    winLo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!foundHi && req_in[i] && (ID_W'(i) >= ptr_q)) begin
        foundHi = 1'b1;
        winHi   = ID_W'(i);
      end
      if (!foundLo && req_in[i]) begin
        foundLo = 1'b1;
        winLo   = ID_W'(i);
      end
    end
    found  = foundHi | foundLo;
    winner = foundHi ? winHi : winLo;
  end

  // Weight of the winner, sampled only when a new grant is loaded so a
  // weight change never alters a burst already in progress.
  always_comb begin
    winField = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        winField = weight_in[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    winWeight = (winField == '0) ? WEIGHT_W'(1) : winField;
  end

  assign hold = active_q && curReq && (credit_q > WEIGHT_W'(1));

`ifdef WRR_ARB_LOCK_EN
  assign lockHold = active_q && curReq && lock_in;
`else
  assign lockHold = 1'b0;
`endif

  // Next-state selection: lock beats credit hold, credit hold beats
  // rearbitration. Rearbitration with no requester returns to idle while
  // leaving the search pointer where it was.
  always_comb begin
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    active_d = active_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    id_d     = id_q;
    if (lockHold) begin
      credit_d = (credit_q > WEIGHT_W'(1)) ? credit_q - WEIGHT_W'(1) : WEIGHT_W'(1);
    end else if (hold) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end else if (found) begin
      cur_d    = winner;
      credit_d = winWeight;
      active_d = 1'b1;
      valid_d  = 1'b1;
      id_d     = winner;
      ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_d[i] = (winner == ID_W'(i));
      end
    end else begin
      credit_d = '0;
      active_d = 1'b0;
      grant_d  = '0;
      valid_d  = 1'b0;
      id_d     = '0;
    end
  end

  // State and output registers; reset aborts any burst and restarts the
  // round-robin search at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      cur_q    <= '0;
      credit_q <= '0;
      active_q <= 1'b0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
      active_q <= active_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
    end
  end

  assign grant_out       = grant_q;
  assign grant_valid_out = valid_q;
  assign grant_id_out    = id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_arbiter
//
// Directed bench for wrr_arbiter (NUM_REQ=3, WEIGHT_W=4). A behavioural model
// tracks "who holds the grant and how many cycles are left" with plain
// integers and is compared against the DUT after every edge; hand-computed
// grant sequences pin the model to the expected arbitration order.
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;

  localparam int N  = 3;
  localparam int WW = 4;
`ifdef WRR_ARB_LOCK_EN
  localparam bit LockBuilt = 1'b1;
`else
  localparam bit LockBuilt = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  reqIn;
  logic [N*WW-1:0] weightIn;
  logic          lockIn;
  logic [N-1:0]  grantOut;
  logic          grantValidOut;
  logic [1:0]    grantIdOut;

  int  tests;
  int  fails;
  bit  checkEn;

  wrr_arbiter #(
    .NUM_REQ (N),
    .WEIGHT_W(WW),
    .ID_W    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_in         (reqIn),
    .weight_in      (weightIn),
`ifdef WRR_ARB_LOCK_EN
    .lock_in        (lockIn),
`endif
    .grant_out      (grantOut),
    .grant_valid_out(grantValidOut),
    .grant_id_out   (grantIdOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mOwner is the requester holding the grant (-1 idle),
  // mLeft the cycles it may still keep it, mNext where the next search starts.
  int mOwner;
  int mLeft;
  int mNext;
  int pick;
  int cand;
  int wgt;
  logic [N-1:0] expGrant;
  logic [1:0]   expId;

  initial begin
    mOwner = -1;
    mLeft  = 0;
    mNext  = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      mOwner = -1;
      mLeft  = 0;
      mNext  = 0;
    end else if (mOwner >= 0 && reqIn[mOwner] && LockBuilt && lockIn) begin
      mLeft = (mLeft > 1) ? mLeft - 1 : 1;
    end else if (mOwner >= 0 && reqIn[mOwner] && mLeft > 1) begin
      mLeft = mLeft - 1;
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        cand = (mNext + k) % N;
        if (pick < 0 && reqIn[cand]) pick = cand;
      end
      if (pick >= 0) begin
        wgt    = int'((weightIn >> (WW * pick)) & 12'hF);
        mOwner = pick;
        mLeft  = (wgt == 0) ? 1 : wgt;
        mNext  = (pick + 1) % N;
      end else begin
        mOwner = -1;
      end
    end
    #1;
    if (checkEn) begin
      expGrant = (mOwner >= 0) ? N'(1 << mOwner) : '0;
      expId    = (mOwner >= 0) ? 2'(mOwner) : 2'd0;
      tests++;
      if (grantOut !== expGrant || grantValidOut !== (mOwner >= 0) || grantIdOut !== expId) begin
        fails++;
        $display("[TB] FAIL model t=%0t grant=%b valid=%b id=%0d, required grant=%b valid=%b id=%0d",
                 $time, grantOut, grantValidOut, grantIdOut, expGrant, (mOwner >= 0), expId);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [N-1:0] req,
                               input logic [N*WW-1:0] w, input logic lk);
    @(negedge clk);
    rst      = r;
    reqIn    = req;
    weightIn = w;
    lockIn   = lk;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] exp);
    logic [1:0] eId;
    eId = exp[2] ? 2'd2 : (exp[1] ? 2'd1 : 2'd0);
    @(posedge clk);
    #2;
    tests++;
    if (grantOut !== exp || grantValidOut !== (|exp) || grantIdOut !== eId) begin
      fails++;
      $display("[TB] FAIL %s t=%0t grant=%b valid=%b id=%0d, required grant=%b valid=%b id=%0d",
               name, $time, grantOut, grantValidOut, grantIdOut, exp, |exp, eId);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] req, input logic [N*WW-1:0] w,
                      input logic lk, input string name, input logic [N-1:0] exp);
    applyStimulus(r, req, w, lk);
    checkOutput(name, exp);
  endtask

  logic [N-1:0] seqEq  [6]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [N-1:0] seqWrr [12] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100,
                                3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
  logic [N-1:0] seqMid [6]  = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010};
  logic [N-1:0]    mixReq [16] = '{3'b101, 3'b101, 3'b110, 3'b011, 3'b010, 3'b111, 3'b111, 3'b000,
                                   3'b100, 3'b111, 3'b001, 3'b111, 3'b110, 3'b011, 3'b111, 3'b000};
  logic [N*WW-1:0] mixW   [16] = '{12'h231, 12'h231, 12'h231, 12'h102, 12'h102, 12'h302, 12'h302, 12'h302,
                                   12'h000, 12'h000, 12'h021, 12'h021, 12'hF21, 12'h121, 12'h121, 12'h121};

  initial begin
    rst      = 1'b1;
    reqIn    = '0;
    weightIn = 12'h111;
    lockIn   = 1'b0;
    checkEn  = 1'b0;
    tests    = 0;
    fails    = 0;

    applyStimulus(1'b1, 3'b000, 12'h111, 1'b0);
    checkEn = 1'b1;
    checkOutput("reset_state", 3'b000);

    // Idle after reset
    for (int c = 0; c < 5; c++) step(1'b0, 3'b000, 12'h111, 1'b0, "idle", 3'b000);

    // Equal weights: plain round robin
    for (int c = 0; c < 6; c++) step(1'b0, 3'b111, 12'h111, 1'b0, "equal_weights", seqEq[c]);

    // Reset ignores requests, then weights r0=3, r1=1, r2=2
    step(1'b1, 3'b111, 12'h213, 1'b0, "reset_ignores_req", 3'b000);
    for (int c = 0; c < 12; c++) step(1'b0, 3'b111, 12'h213, 1'b0, "weighted", seqWrr[c]);

    // Reset mid-burst aborts and restarts the search at requester 0
    step(1'b0, 3'b111, 12'h213, 1'b0, "weighted_burst", 3'b001);
    step(1'b1, 3'b111, 12'h213, 1'b0, "reset_mid_burst", 3'b000);
    step(1'b0, 3'b111, 12'h213, 1'b0, "restart_from_0", 3'b001);

    // Grantee drops request: new grantee on the next edge, no idle gap
    step(1'b1, 3'b000, 12'h204, 1'b0, "reset", 3'b000);
    step(1'b0, 3'b001, 12'h204, 1'b0, "drop_burst", 3'b001);
    step(1'b0, 3'b001, 12'h204, 1'b0, "drop_burst", 3'b001);
    step(1'b0, 3'b100, 12'h204, 1'b0, "drop_switch", 3'b100);
    step(1'b0, 3'b100, 12'h204, 1'b0, "sole_r2_hold", 3'b100);
    step(1'b0, 3'b100, 12'h204, 1'b0, "sole_r2_regrant", 3'b100);
    step(1'b0, 3'b000, 12'h204, 1'b0, "release_idle", 3'b000);

    // Weight change mid-burst only applies to the next grant
    step(1'b1, 3'b000, 12'h113, 1'b0, "reset", 3'b000);
    for (int c = 0; c < 6; c++)
      step(1'b0, 3'b011, (c == 0) ? 12'h113 : 12'h111, 1'b0, "weight_mid_burst", seqMid[c]);

    // Zero weight behaves as one; sole requester regranted every cycle
    step(1'b1, 3'b000, 12'h110, 1'b0, "reset", 3'b000);
    for (int c = 0; c < 4; c++) step(1'b0, 3'b001, 12'h110, 1'b0, "zero_weight", 3'b001);
    step(1'b1, 3'b001, 12'h110, 1'b0, "reset_stream", 3'b000);
    step(1'b1, 3'b001, 12'h110, 1'b0, "reset_held", 3'b000);
    step(1'b0, 3'b001, 12'h110, 1'b0, "after_reset", 3'b001);

    // Mixed patterns checked by the model
    step(1'b1, 3'b000, 12'h111, 1'b0, "reset", 3'b000);
    for (int c = 0; c < 16; c++) applyStimulus(1'b0, mixReq[c], mixW[c], 1'b0);

`ifdef WRR_ARB_LOCK_EN
    // Lock holds r0 for four cycles despite weight 1
    step(1'b1, 3'b000, 12'h111, 1'b0, "reset", 3'b000);
    step(1'b0, 3'b011, 12'h111, 1'b0, "lock_first", 3'b001);
    for (int c = 0; c < 3; c++) step(1'b0, 3'b011, 12'h111, 1'b1, "lock_hold", 3'b001);
    step(1'b0, 3'b011, 12'h111, 1'b0, "lock_release", 3'b010);
    step(1'b0, 3'b011, 12'h111, 1'b0, "after_lock", 3'b001);
`endif

    applyStimulus(1'b0, 3'b000, 12'h111, 1'b0);
    applyStimulus(1'b0, 3'b000, 12'h111, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
